// File: rtl/tms_rom_arbiter.sv
// Single-port program-ROM arbiter for the TMS1x00: Wishbone load/verify vs. CPU fetch,
// with run/ROM-size control and a running checksum of loaded bytes.
module tms_rom_arbiter #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned ADDR_W   = 11
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              cpu_rom_req,
  input  logic [ADDR_W-1:0] cpu_rom_addr,
  output logic [7:0]        cpu_rom_data,
  output logic              cpu_rom_valid,
  output logic              cpu_rst_o,
  output logic              cpu_tms1100_o,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  localparam int unsigned RANGE_W    = 14;
  localparam int unsigned SUM_W      = 16;
  localparam logic [11:0] CTRL_IDX   = 12'h800;
  localparam logic [11:0] STATUS_IDX = 12'h801;

  typedef enum logic [2:0] {IDLE, CPU_RD, CPU_RSP, WB_RD, WB_RSP, WB_WR, WB_REG} state_t;
  typedef enum logic [1:0] {REG_NONE, REG_CTRL, REG_STATUS} reg_sel_t;

  state_t           state;
  reg_sel_t         reg_sel;
  logic             reg_we;
  logic [2:0]       reg_wdata;
  logic             run;
  logic             tms1100;
  logic             wperr;
  logic [SUM_W-1:0] sum;

  logic             in_range_c;
  logic             wb_req_c;
  logic             rom_win_c;
  reg_sel_t         reg_sel_c;
  logic             unused_c;

  // ROM addresses wrap at 1 KB in TMS1000 mode by dropping the top address bit.
  function automatic logic [ADDR_W-1:0] rom_mask(input logic [ADDR_W-1:0] a, input logic big);
    logic [ADDR_W-1:0] m;
    m           = a;
    m[ADDR_W-1] = a[ADDR_W-1] & big;
    return m;
  endfunction

  // A request is not taken while its own ack is still showing.
  assign in_range_c = (wbs_adr_i[31:RANGE_W] == BASE_ADR[31:RANGE_W]);
  assign wb_req_c   = wbs_cyc_i && wbs_stb_i && in_range_c && !wbs_ack_o;
  assign rom_win_c  = ~wbs_adr_i[RANGE_W-1];
  assign unused_c   = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_adr_i[1:0]};

  always_comb begin
    reg_sel_c = REG_NONE;
    if (wbs_adr_i[RANGE_W-1:2] == CTRL_IDX) begin
      reg_sel_c = REG_CTRL;
    end else if (wbs_adr_i[RANGE_W-1:2] == STATUS_IDX) begin
      reg_sel_c = REG_STATUS;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      reg_sel       <= REG_NONE;
      reg_we        <= 1'b0;
      reg_wdata     <= '0;
      run           <= 1'b0;
      tms1100       <= 1'b0;
      wperr         <= 1'b0;
      sum           <= '0;
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= '0;
      cpu_rom_data  <= '0;
      cpu_rom_valid <= 1'b0;
      cpu_rst_o     <= 1'b1;
      cpu_tms1100_o <= 1'b0;
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= '0;
      cpu_rom_valid <= 1'b0;
      cpu_rst_o     <= ~run;
      cpu_tms1100_o <= tms1100;
      case (state)
        IDLE: begin
          if (cpu_rom_req && run && !cpu_rom_valid) begin
            state    <= CPU_RD;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= rom_mask(cpu_rom_addr, tms1100);
          end else if (wb_req_c && rom_win_c) begin
            mem_addr <= rom_mask(wbs_adr_i[ADDR_W+1:2], tms1100);
            if (wbs_we_i) begin
              state     <= WB_WR;
              mem_wdata <= wbs_dat_i[7:0];
              // Writes while running are dropped and flagged; the checksum tracks stored bytes only.
              if (run) begin
                wperr <= 1'b1;
              end else if (wbs_sel_i[0]) begin
                mem_en <= 1'b1;
                mem_we <= 1'b1;
                sum    <= sum + SUM_W'(wbs_dat_i[7:0]);
              end
            end else begin
              state  <= WB_RD;
              mem_en <= 1'b1;
              mem_we <= 1'b0;
            end
          end else if (wb_req_c) begin
            state     <= WB_REG;
            reg_sel   <= reg_sel_c;
            reg_we    <= wbs_we_i;
            reg_wdata <= wbs_dat_i[2:0];
          end
        end
        CPU_RD: begin
          mem_en <= 1'b0;
          state  <= CPU_RSP;
        end
        CPU_RSP: begin
          cpu_rom_data  <= mem_rdata;
          cpu_rom_valid <= 1'b1;
          state         <= IDLE;
        end
        WB_RD: begin
          mem_en <= 1'b0;
          state  <= WB_RSP;
        end
        WB_RSP: begin
          wbs_ack_o <= 1'b1;
          wbs_dat_o <= {24'b0, mem_rdata};
          state     <= IDLE;
        end
        WB_WR: begin
          wbs_ack_o <= 1'b1;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          state     <= IDLE;
        end
        WB_REG: begin
          wbs_ack_o <= 1'b1;
          state     <= IDLE;
          if (reg_we) begin
            if (reg_sel == REG_CTRL) begin
              run     <= reg_wdata[0];
              tms1100 <= reg_wdata[1];
              if (reg_wdata[2]) begin
                sum   <= '0;
                wperr <= 1'b0;
              end
            end
          end else if (reg_sel == REG_CTRL) begin
            wbs_dat_o <= {30'b0, tms1100, run};
          end else if (reg_sel == REG_STATUS) begin
            wbs_dat_o <= {14'b0, run, wperr, sum};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tms_rom_arbiter.sv
// Bench for tms_rom_arbiter: SRAM model, table-driven Wishbone vectors with a scoreboard,
// and hand-written sequences for contention, write protection and mid-transaction reset.
module tb_tms_rom_arbiter;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam int unsigned AW     = 11;
  localparam logic [31:0] CTRL   = BASE + 32'h2000;
  localparam logic [31:0] STATUS = BASE + 32'h2004;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [31:0]   adr, wdat;
  logic          ack;
  logic [31:0]   rdat;
  logic          req;
  logic [AW-1:0] req_addr;
  logic [7:0]    cpu_data;
  logic          cpu_valid;
  logic          cpu_rst;
  logic          cpu_tms;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = 8'h00;
  logic [7:0]    sram [2**AW];
  int            we_cnt = 0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;
  exp_t wb_q[$];
  exp_t cpu_q[$];

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[10];

  logic rst_at_ack;

  tms_rom_arbiter #(.BASE_ADR(BASE), .ADDR_W(AW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .cpu_rom_req(req), .cpu_rom_addr(req_addr), .cpu_rom_data(cpu_data),
    .cpu_rom_valid(cpu_valid), .cpu_rst_o(cpu_rst), .cpu_tms1100_o(cpu_tms),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous read-first SRAM: data valid the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      mem_rdata <= sram[mem_addr];
    end
    if (mem_en && mem_we) we_cnt <= we_cnt + 1;
  end

  function automatic logic [31:0] rom(input int b);
    return BASE + 32'(b * 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  // One Wishbone transfer: expected data goes on the scoreboard, popped when ack appears.
  task automatic wb_xfer(input string name, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp, input int exp_lat);
    int   lat;
    bit   got;
    exp_t e;
    e.name = name;
    e.data = exp;
    wb_q.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = 4'h1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      tick();
      lat++;
      if (ack) got = 1'b1;
    end
    e = wb_q.pop_front();
    if (got) begin
      rst_at_ack = cpu_rst;
      check({e.name, " data"}, rdat, e.data);
      check({e.name, " latency"}, 32'(lat), 32'(exp_lat));
    end else begin
      note_timeout(e.name);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic cpu_fetch(input string name, input logic [AW-1:0] a, input logic [7:0] exp);
    int   lat;
    bit   got;
    exp_t e;
    e.name = name;
    e.data = 32'(exp);
    cpu_q.push_back(e);
    req = 1'b1; req_addr = a;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      tick();
      lat++;
      if (cpu_valid) got = 1'b1;
    end
    e = cpu_q.pop_front();
    if (got) begin
      check({e.name, " data"}, 32'(cpu_data), e.data);
      check({e.name, " latency"}, 32'(lat), 32'd3);
    end else begin
      note_timeout(e.name);
    end
    req = 1'b0;
    tick();
  endtask

  initial begin
    int   n;
    int   we_before;
    int   cpu_lat, wb_lat;
    bit   cpu_done, wb_done;
    exp_t e;

    for (int i = 0; i < 2**AW; i++) sram[i] = 8'h00;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = '0; wdat = '0; req = 1'b0; req_addr = '0; rst_at_ack = 1'b0;

    // Reset held two cycles
    tick();
    tick();
    check("rst ack", 32'(ack), 32'd0);
    check("rst dat_o", rdat, 32'd0);
    check("rst cpu valid/data", {23'b0, cpu_valid, cpu_data}, 32'd0);
    check("rst cpu_rst/tms", {30'b0, cpu_rst, cpu_tms}, 32'h2);
    check("rst mem ctl", {30'b0, mem_en, mem_we}, 32'd0);
    check("rst mem addr/wdata", {13'b0, mem_addr, mem_wdata}, 32'd0);
    rst = 1'b0;
    tick();
    wb_xfer("rst status", 1'b0, STATUS, '0, 32'h0, 2);
    wb_xfer("rst ctrl", 1'b0, CTRL, '0, 32'h0, 2);

    // Load/verify in TMS1100 mode
    wb_xfer("ctrl tms1100", 1'b1, CTRL, 32'h2, 32'h0, 2);
    check("tms1100 out", 32'(cpu_tms), 32'd1);
    vecs[0] = '{"wr b0",       1'b1, rom(0),             32'h12, 32'h0,   2};
    vecs[1] = '{"wr b1",       1'b1, rom(1),             32'h34, 32'h0,   2};
    vecs[2] = '{"wr b7ff",     1'b1, rom(12'h7FF),       32'hFF, 32'h0,   2};
    vecs[3] = '{"rd b0",       1'b0, rom(0),             32'h0,  32'h12,  3};
    vecs[4] = '{"rd b1",       1'b0, rom(1),             32'h0,  32'h34,  3};
    vecs[5] = '{"rd b7ff",     1'b0, rom(12'h7FF),       32'h0,  32'hFF,  3};
    vecs[6] = '{"status sum",  1'b0, STATUS,             32'h0,  32'h145, 2};
    vecs[7] = '{"rd hole",     1'b0, BASE + 32'h2008,    32'h0,  32'h0,   2};
    vecs[8] = '{"wr hole",     1'b1, BASE + 32'h3000,    32'h7,  32'h0,   2};
    vecs[9] = '{"ctrl rb",     1'b0, CTRL,               32'h0,  32'h2,   2};
    for (int i = 0; i < 10; i++) begin
      wb_xfer(vecs[i].name, vecs[i].we, vecs[i].adr, vecs[i].wdat, vecs[i].exp, vecs[i].lat);
    end

    // Outside the 16 KB window: never acked
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h4000;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack) n++;
    end
    check("out of range acks", 32'(n), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    tick();

    // Wraparound in TMS1000 mode
    wb_xfer("ctrl tms1000", 1'b1, CTRL, 32'h0, 32'h0, 2);
    wb_xfer("wr b400", 1'b1, rom(12'h400), 32'hA5, 32'h0, 2);
    wb_xfer("rd b0 wrap", 1'b0, rom(0), 32'h0, 32'hA5, 3);
    wb_xfer("rd b400 wrap", 1'b0, rom(12'h400), 32'h0, 32'hA5, 3);
    wb_xfer("status wrap", 1'b0, STATUS, 32'h0, 32'h1EA, 2);

    // RUN=1: core reset releases one cycle after the ack
    wb_xfer("ctrl run", 1'b1, CTRL, 32'h1, 32'h0, 2);
    check("cpu_rst at ack", 32'(rst_at_ack), 32'd1);
    check("cpu_rst after", 32'(cpu_rst), 32'd0);
    cpu_fetch("cpu b400", 11'h400, 8'hA5);

    // Write protection while running
    we_before = we_cnt;
    wb_xfer("wr protected", 1'b1, rom(1), 32'h77, 32'h0, 2);
    check("protected mem_we", 32'(we_cnt - we_before), 32'd0);
    wb_xfer("rd b1 kept", 1'b0, rom(1), 32'h0, 32'h34, 3);
    wb_xfer("status wperr", 1'b0, STATUS, 32'h0, 32'h0003_01EA, 2);
    wb_xfer("ctrl clrsum", 1'b1, CTRL, 32'h5, 32'h0, 2);
    wb_xfer("status cleared", 1'b0, STATUS, 32'h0, 32'h0002_0000, 2);
    wb_xfer("ctrl clrsum rd0", 1'b0, CTRL, 32'h0, 32'h1, 2);

    // Back to RUN=0: fetches are ignored, reload byte 0
    wb_xfer("ctrl stop", 1'b1, CTRL, 32'h2, 32'h0, 2);
    check("cpu_rst reassert", 32'(cpu_rst), 32'd1);
    req = 1'b1; req_addr = '0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_valid) n++;
    end
    check("req while stopped", 32'(n), 32'd0);
    req = 1'b0;
    tick();
    wb_xfer("reload b0", 1'b1, rom(0), 32'h12, 32'h0, 2);
    wb_xfer("status reload", 1'b0, STATUS, 32'h0, 32'h12, 2);

    // stb held past its ack must not start a second transfer
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = CTRL;
    n = 0;
    while (!ack && n < 20) begin
      tick();
      n++;
    end
    check("hold ack seen", 32'(ack), 32'd1);
    check("hold data", rdat, 32'h2);
    tick();
    cyc = 1'b0; stb = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack) n++;
    end
    check("no re-accept", 32'(n), 32'd0);

    // Contention: CPU first, Wishbone right behind
    wb_xfer("ctrl run 1100", 1'b1, CTRL, 32'h3, 32'h0, 2);
    e.name = "cont cpu"; e.data = 32'h34; cpu_q.push_back(e);
    e.name = "cont wb";  e.data = 32'h12; wb_q.push_back(e);
    req = 1'b1; req_addr = 11'h001;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = rom(0);
    cpu_done = 1'b0; wb_done = 1'b0; cpu_lat = 0; wb_lat = 0;
    for (int i = 1; i <= 20 && !(cpu_done && wb_done); i++) begin
      tick();
      if (cpu_valid && !cpu_done) begin
        cpu_done = 1'b1;
        cpu_lat = i;
        e = cpu_q.pop_front();
        check(e.name, 32'(cpu_data), e.data);
        req = 1'b0;
      end
      if (ack && !wb_done) begin
        wb_done = 1'b1;
        wb_lat = i;
        e = wb_q.pop_front();
        check(e.name, rdat, e.data);
        cyc = 1'b0; stb = 1'b0;
      end
    end
    if (cpu_done) check("cont cpu latency", 32'(cpu_lat), 32'd3);
    else note_timeout("cont cpu");
    if (wb_done) check("cont wb latency", 32'(wb_lat), 32'd6);
    else note_timeout("cont wb");
    req = 1'b0; cyc = 1'b0; stb = 1'b0;
    tick();

    // Reset in the middle of a Wishbone ROM read
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = rom(0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    check("midrst cpu_rst", 32'(cpu_rst), 32'd1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack) n++;
    end
    check("midrst no ack", 32'(n), 32'd0);
    check("midrst tms", 32'(cpu_tms), 32'd0);
    wb_xfer("midrst status", 1'b0, STATUS, 32'h0, 32'h0, 2);
    wb_xfer("midrst rd b0", 1'b0, rom(0), 32'h0, 32'h12, 3);
    wb_xfer("midrst rd b7ff wrap", 1'b0, rom(12'h7FF), 32'h0, 32'h0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
